// File: rtl/prime_job_scheduler_pkg.sv
// Shared constants for the prime job scheduler: bus map, FSM encoding,
// status/control bit positions.
package prime_sched_pkg;

   localparam logic [15:0] A_ARG  = 16'h0288;
   localparam logic [15:0] A_RES  = 16'h0298;
   localparam logic [15:0] A_STAT = 16'h02A0;
   localparam logic [15:0] A_CTRL = 16'h02A8;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_START = 2'b01,
      S_WAIT  = 2'b11,
      S_STORE = 2'b10
   } sched_state_t;

   localparam int ST_STATE     = 0;
   localparam int ST_BUSY      = 2;
   localparam int ST_JOB_EMPTY = 3;
   localparam int ST_JOB_FULL  = 4;
   localparam int ST_RES_EMPTY = 5;
   localparam int ST_RES_FULL  = 6;
   localparam int ST_ERR       = 7;

   localparam int CTRL_CLR_ERR = 0;
   localparam int CTRL_FLUSH   = 1;

endpackage

// File: rtl/prime_job_scheduler_fifo.sv
// Synchronous FIFO with flush; full/empty derived from an extra-bit count.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     n_reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (PW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!n_reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/prime_job_scheduler.sv
// Bus-attached scheduler feeding prime indices to the n-th-prime engine one at
// a time, queueing results and pulsing irq per stored result.
module prime_job_scheduler
   import prime_sched_pkg::*;
#(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned AW      = 10,
   parameter int unsigned RW      = 32,
   parameter int unsigned TIMEOUT = 65535
) (
   input  logic          clk,
   input  logic          n_reset,
   input  logic [15:0]   saddress,
   input  logic          srd,
   input  logic          swr,
   input  logic [31:0]   sdata_in,
   output logic [31:0]   sdata_out,
   output logic [AW-1:0] eng_arg,
   output logic          eng_start,
   input  logic          eng_done,
   input  logic [RW-1:0] eng_result,
   output logic          irq
);

   localparam int unsigned WDW = $clog2(TIMEOUT + 1);
   localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   sched_state_t   state;
   logic           srd_q, srd_p, swr_q, swr_p;
   logic           rd_ev, wr_ev;
   logic           wr_arg, wr_ctrl, rd_res;
   logic           flush, clr_err, arg_bad;
   logic           job_push, job_pop, res_push, res_pop;
   logic           job_full, job_empty, res_full, res_empty;
   logic [AW-1:0]  job_head, last_arg;
   logic [RW-1:0]  res_head, result;
   logic [CW-1:0]  job_count, res_count;
   logic [WDW-1:0] wd;
   logic           err, drop_q, drop_now;
   logic [7:0]     status;
   logic           unused_bits;

   assign rd_ev    = srd_q & ~srd_p;
   assign wr_ev    = swr_q & ~swr_p;
   assign wr_arg   = wr_ev && (saddress == A_ARG);
   assign wr_ctrl  = wr_ev && (saddress == A_CTRL);
   assign rd_res   = rd_ev && (saddress == A_RES);
   assign flush    = wr_ctrl & sdata_in[CTRL_FLUSH];
   assign clr_err  = wr_ctrl & sdata_in[CTRL_CLR_ERR];
   assign arg_bad  = wr_arg && ((sdata_in[AW-1:0] == '0) || job_full);
   assign job_push = wr_arg && !arg_bad;
   assign job_pop  = (state == S_IDLE) && !job_empty && !res_full && !flush;
   assign res_pop  = rd_res && !res_empty;
   // A flush while a job is in flight marks its result for discard at STORE.
   assign drop_now = drop_q | flush;
   assign res_push = (state == S_STORE) && !drop_now;
   assign unused_bits = ^{sdata_in, job_count, res_count};

   always_comb begin
      status                   = '0;
      status[ST_STATE +: 2]    = state;
      status[ST_BUSY]          = (state != S_IDLE);
      status[ST_JOB_EMPTY]     = job_empty;
      status[ST_JOB_FULL]      = job_full;
      status[ST_RES_EMPTY]     = res_empty;
      status[ST_RES_FULL]      = res_full;
      status[ST_ERR]           = err;
   end

   sync_fifo #(.WIDTH(AW), .DEPTH(DEPTH)) u_job_fifo (
      .clk(clk), .n_reset(n_reset), .push(job_push), .pop(job_pop), .flush(flush),
      .din(sdata_in[AW-1:0]), .head(job_head), .full(job_full), .empty(job_empty),
      .count(job_count)
   );

   sync_fifo #(.WIDTH(RW), .DEPTH(DEPTH)) u_res_fifo (
      .clk(clk), .n_reset(n_reset), .push(res_push), .pop(res_pop), .flush(flush),
      .din(result), .head(res_head), .full(res_full), .empty(res_empty),
      .count(res_count)
   );

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         state     <= S_IDLE;
         srd_q     <= 1'b0;
         srd_p     <= 1'b0;
         swr_q     <= 1'b0;
         swr_p     <= 1'b0;
         sdata_out <= '0;
         eng_arg   <= '0;
         eng_start <= 1'b0;
         irq       <= 1'b0;
         err       <= 1'b0;
         drop_q    <= 1'b0;
         last_arg  <= '0;
         result    <= '0;
         wd        <= '0;
      end else begin
         srd_q     <= srd;
         srd_p     <= srd_q;
         swr_q     <= swr;
         swr_p     <= swr_q;
         eng_start <= 1'b0;
         irq       <= 1'b0;
         if (job_push) last_arg <= sdata_in[AW-1:0];
         if (clr_err)  err <= 1'b0;
         if (arg_bad)  err <= 1'b1;
         if (flush && state != S_IDLE) drop_q <= 1'b1;

         case (state)
            S_IDLE: begin
               drop_q <= 1'b0;
               if (job_pop) begin
                  eng_arg   <= job_head;
                  eng_start <= 1'b1;
                  state     <= S_START;
               end
            end
            S_START: begin
               wd    <= '0;
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (eng_done) begin
                  result <= eng_result;
                  state  <= S_STORE;
               end else if (wd == WD_LAST) begin
                  result <= '1;
                  err    <= 1'b1;
                  state  <= S_STORE;
               end else begin
                  wd <= wd + WDW'(1);
               end
            end
            default: begin
               irq   <= !drop_now;
               state <= S_IDLE;
            end
         endcase

         if (rd_ev) begin
            case (saddress)
               A_ARG:   sdata_out <= 32'(last_arg);
               A_RES:   sdata_out <= res_empty ? '0 : 32'(res_head);
               A_STAT:  sdata_out <= 32'(status);
               default: sdata_out <= '0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_prime_job_scheduler.sv
// Directed bench: main instance with default watchdog plus a TIMEOUT=16
// instance whose engine never answers.
module tb_prime_job_scheduler;
   import prime_sched_pkg::*;

   logic        clk = 1'b0;
   logic        n_reset = 1'b0;
   logic [15:0] saddress = '0;
   logic        srd = 1'b0;
   logic        swr = 1'b0;
   logic [31:0] sdata_in = '0;

   logic [31:0] sdata_out, to_sdata_out;
   logic [9:0]  eng_arg, to_eng_arg;
   logic        eng_start, to_eng_start;
   logic        irq, to_irq;
   logic        eng_done = 1'b0;
   logic [31:0] eng_result = '0;
   logic        to_eng_done = 1'b0;
   logic [31:0] to_eng_result = '0;

   int n_pass = 0, n_fail = 0, n_total = 0;
   int n_starts = 0, irq_cnt = 0, done_cnt = 0;
   logic [9:0] start_arg = '0;
   bit  eng_en = 1'b1;
   int  eng_delay = 20;
   int  eng_cnt = 0;
   logic [9:0] eng_cur = '0;

   always #5 clk = ~clk;

   prime_job_scheduler dut (
      .clk(clk), .n_reset(n_reset), .saddress(saddress), .srd(srd), .swr(swr),
      .sdata_in(sdata_in), .sdata_out(sdata_out), .eng_arg(eng_arg),
      .eng_start(eng_start), .eng_done(eng_done), .eng_result(eng_result), .irq(irq)
   );

   prime_job_scheduler #(.TIMEOUT(16)) dut_to (
      .clk(clk), .n_reset(n_reset), .saddress(saddress), .srd(srd), .swr(swr),
      .sdata_in(sdata_in), .sdata_out(to_sdata_out), .eng_arg(to_eng_arg),
      .eng_start(to_eng_start), .eng_done(to_eng_done), .eng_result(to_eng_result),
      .irq(to_irq)
   );

   function automatic logic [31:0] nth_prime(input logic [9:0] n);
      int c;
      bit p;
      c = 0;
      for (int unsigned v = 2; v < 2000; v++) begin
         p = 1'b1;
         for (int unsigned d = 2; d * d <= v; d++)
            if (v % d == 0) p = 1'b0;
         if (p) begin
            c++;
            if (c == int'(n)) return v;
         end
      end
      return 32'd0;
   endfunction

   // Engine model: answers nth_prime(arg) eng_delay cycles after start.
   always @(posedge clk) begin
      eng_done <= 1'b0;
      if (eng_start && eng_en) begin
         eng_cnt <= eng_delay;
         eng_cur <= eng_arg;
      end else if (eng_cnt > 0) begin
         eng_cnt <= eng_cnt - 1;
         if (eng_cnt == 1) begin
            eng_done   <= 1'b1;
            eng_result <= nth_prime(eng_cur);
         end
      end
   end

   always @(negedge clk) begin
      if (eng_start) begin
         n_starts++;
         start_arg = eng_arg;
      end
      if (irq) irq_cnt++;
      if (eng_done) done_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
      @(negedge clk);
      saddress = a;
      sdata_in = d;
      swr = 1'b1;
      @(negedge clk);
      swr = 1'b0;
      @(negedge clk);
   endtask

   task automatic bus_read(input logic [15:0] a, output logic [31:0] d, output logic [31:0] d_to);
      @(negedge clk);
      saddress = a;
      srd = 1'b1;
      @(negedge clk);
      @(negedge clk);
      d = sdata_out;
      d_to = to_sdata_out;
      srd = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      n_reset = 1'b0;
      repeat (3) @(negedge clk);
      n_reset = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] rd, rd_to;
      int base_s, base_i, base_d, k;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_sdata_out", sdata_out, 32'h0);
      check("rst_eng_start_arg", {21'h0, eng_start, eng_arg}, 32'h0);
      check("rst_irq", {31'h0, irq}, 32'h0);
      n_reset = 1'b1;
      @(negedge clk);
      bus_read(A_STAT, rd, rd_to);
      check("rst_status", rd, 32'h28);

      // Single job: arg 5 -> 11
      eng_en = 1'b1;
      eng_delay = 20;
      base_s = n_starts; base_i = irq_cnt; base_d = done_cnt;
      bus_write(A_ARG, 32'd5);
      for (int i = 0; i < 80 && irq_cnt == base_i; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      check("job5_starts", n_starts - base_s, 1);
      check("job5_start_arg", 32'(start_arg), 32'd5);
      check("job5_irqs", irq_cnt - base_i, 1);
      bus_read(A_RES, rd, rd_to);
      check("job5_result", rd, 32'd11);
      bus_read(A_RES, rd, rd_to);
      check("job5_empty_read", rd, 32'h0);
      bus_read(A_ARG, rd, rd_to);
      check("job5_last_arg", rd, 32'd5);

      // Job FIFO overflow with stalled engine
      do_reset();
      eng_en = 1'b0;
      for (int a = 1; a <= 6; a++) bus_write(A_ARG, 32'(a));
      bus_read(A_STAT, rd, rd_to);
      check("ovf_status", rd, 32'hB7);
      bus_read(A_ARG, rd, rd_to);
      check("ovf_last_arg", rd, 32'd5);
      bus_write(A_CTRL, 32'h1);
      bus_read(A_STAT, rd, rd_to);
      check("ovf_err_cleared", rd, 32'h37);

      // Watchdog abort on the TIMEOUT=16 instance
      do_reset();
      bus_write(A_ARG, 32'd7);
      for (int i = 0; i < 50 && !to_eng_start; i++) @(negedge clk);
      check("to_start_seen", {31'h0, to_eng_start}, 32'h1);
      k = 0;
      while (!to_irq && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("to_start_to_irq", k, 18);
      bus_read(A_RES, rd, rd_to);
      check("to_result", rd_to, 32'hFFFF_FFFF);
      bus_read(A_STAT, rd, rd_to);
      check("to_status", rd_to, 32'hA8);

      // Result FIFO full blocks further starts
      do_reset();
      eng_en = 1'b1;
      eng_delay = 3;
      base_s = n_starts; base_i = irq_cnt;
      for (int a = 1; a <= 4; a++) bus_write(A_ARG, 32'(a));
      for (int i = 0; i < 200 && irq_cnt - base_i < 4; i++) @(negedge clk);
      repeat (2) @(negedge clk);
      bus_write(A_ARG, 32'd5);
      repeat (30) @(negedge clk);
      check("full_starts", n_starts - base_s, 4);
      bus_read(A_STAT, rd, rd_to);
      check("full_status", rd, 32'h40);
      bus_read(A_RES, rd, rd_to);
      check("full_pop0", rd, 32'd2);
      for (int i = 0; i < 100 && irq_cnt - base_i < 5; i++) @(negedge clk);
      repeat (2) @(negedge clk);
      check("full_starts_after", n_starts - base_s, 5);
      check("full_fifth_arg", 32'(start_arg), 32'd5);
      bus_read(A_RES, rd, rd_to);
      check("full_pop1", rd, 32'd3);
      bus_read(A_RES, rd, rd_to);
      check("full_pop2", rd, 32'd5);
      bus_read(A_RES, rd, rd_to);
      check("full_pop3", rd, 32'd7);
      bus_read(A_RES, rd, rd_to);
      check("full_pop4", rd, 32'd11);
      bus_read(A_RES, rd, rd_to);
      check("full_pop_empty", rd, 32'h0);

      // Flush during WAIT discards the in-flight result
      do_reset();
      eng_delay = 20;
      base_i = irq_cnt; base_d = done_cnt;
      bus_write(A_ARG, 32'd6);
      for (int i = 0; i < 20 && !eng_start; i++) @(negedge clk);
      bus_write(A_CTRL, 32'h2);
      repeat (40) @(negedge clk);
      check("flush_done_seen", done_cnt - base_d, 1);
      check("flush_no_irq", irq_cnt - base_i, 0);
      bus_read(A_STAT, rd, rd_to);
      check("flush_status", rd, 32'h28);
      bus_read(A_RES, rd, rd_to);
      check("flush_res_empty", rd, 32'h0);

      // Reset during WAIT; late done must be ignored
      base_s = n_starts; base_i = irq_cnt; base_d = done_cnt;
      bus_write(A_ARG, 32'd8);
      for (int i = 0; i < 20 && !eng_start; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      n_reset = 1'b0;
      @(negedge clk);
      n_reset = 1'b1;
      check("midrst_sdata_out", sdata_out, 32'h0);
      check("midrst_eng_arg", 32'(eng_arg), 32'h0);
      check("midrst_start_irq", {30'h0, eng_start, irq}, 32'h0);
      repeat (40) @(negedge clk);
      check("midrst_done_seen", done_cnt - base_d, 1);
      check("midrst_no_irq", irq_cnt - base_i, 0);
      check("midrst_starts", n_starts - base_s, 1);
      bus_read(A_STAT, rd, rd_to);
      check("midrst_status", rd, 32'h28);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
